// File: rtl/regfile_sequencer.sv
// regfile_sequencer: one command per handshake into a 2R/1W bank; ALU/MOV = READ then WRITE, LDI = WRITE, CLR = NREG-cycle sweep.
// Cmd_Ready is high only in IDLE, so upstream stalls for the whole command. Optional FLAGS_EN adds Flag_Z/Flag_C.
module regfile_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NREG   = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [2:0]        Cmd_Op,
  input  logic [ADDR_W-1:0] Cmd_Rd,
  input  logic [ADDR_W-1:0] Cmd_Ra,
  input  logic [ADDR_W-1:0] Cmd_Rb,
  input  logic [DATA_W-1:0] Cmd_Imm,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  input  logic [DATA_W-1:0] Out_A,
  input  logic [DATA_W-1:0] Out_B,
  output logic [ADDR_W-1:0] Addr_WR,
  output logic              WR,
  output logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] Result
`ifdef FLAGS_EN
  ,
  output logic              Flag_Z,
  output logic              Flag_C
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [ADDR_W-1:0] addr_wr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] alu_res;
  logic              accept;
  logic              clr_last;

  assign accept   = Cmd_Valid && Cmd_Ready;
  assign clr_last = (addr_wr_q == ADDR_W'(NREG - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid) begin
          case (Cmd_Op)
            OP_LDI:  state_d = ST_WRITE;
            OP_CLR:  state_d = ST_CLEAR;
            default: state_d = ST_READ;
          endcase
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and write strobes decode purely from state so they cannot glitch on inputs.
  always_comb begin
    Cmd_Ready = (state_q == ST_IDLE);
    WR        = (state_q == ST_WRITE) || (state_q == ST_CLEAR);
    Done      = (state_q == ST_WRITE) || ((state_q == ST_CLEAR) && clr_last);
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = Out_A + Out_B;
      OP_SUB:  alu_res = Out_A - Out_B;
      OP_AND:  alu_res = Out_A & Out_B;
      OP_OR:   alu_res = Out_A | Out_B;
      OP_XOR:  alu_res = Out_A ^ Out_B;
      OP_MOV:  alu_res = Out_A;
      default: alu_res = '0;
    endcase
  end

  // addr_wr_q doubles as the CLEAR sweep counter; din_q holds the operand-derived result between READ and WRITE.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_wr_q <= '0;
      din_q     <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q <= Cmd_Op;
        rd_q <= Cmd_Rd;
        case (Cmd_Op)
          OP_LDI: begin
            addr_wr_q <= Cmd_Rd;
            din_q     <= Cmd_Imm;
          end
          OP_CLR: begin
            addr_wr_q <= '0;
            din_q     <= '0;
          end
          default: begin
            addr_a_q <= Cmd_Ra;
            addr_b_q <= Cmd_Rb;
          end
        endcase
      end
      if (state_q == ST_READ) begin
        addr_wr_q <= rd_q;
        din_q     <= alu_res;
      end
      if (state_q == ST_CLEAR) begin
        addr_wr_q <= addr_wr_q + 1'b1;
      end
      if (WR) begin
        result_q <= din_q;
      end
    end
  end

  assign Addr_A  = addr_a_q;
  assign Addr_B  = addr_b_q;
  assign Addr_WR = addr_wr_q;
  assign DIN     = din_q;
  assign Result  = result_q;

`ifdef FLAGS_EN
  logic carry_q, carry_d;
  logic flag_z_q, flag_c_q;

  // Unsigned add overflows exactly when the truncated sum is below an operand; SUB borrows when A < B.
  always_comb begin
    carry_d = ((op_q == OP_ADD) && (alu_res < Out_A)) ||
              ((op_q == OP_SUB) && (Out_A < Out_B));
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (accept) begin
        carry_q <= 1'b0;
      end
      if (state_q == ST_READ) begin
        carry_q <= carry_d;
      end
      if (Done) begin
        flag_z_q <= (din_q == '0);
        flag_c_q <= carry_q;
      end
    end
  end

  assign Flag_Z = flag_z_q;
  assign Flag_C = flag_c_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural bank plus array/arithmetic reference model, randomized commands.
module tb_regfile_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Cmd_Valid = 1'b0;
  logic       Cmd_Ready;
  logic [2:0] Cmd_Op = '0;
  logic [3:0] Cmd_Rd = '0, Cmd_Ra = '0, Cmd_Rb = '0;
  logic [7:0] Cmd_Imm = '0;
  logic [3:0] Addr_A, Addr_B, Addr_WR;
  logic [7:0] Out_A, Out_B, DIN, Result;
  logic       WR, Done;
`ifdef FLAGS_EN
  logic       Flag_Z, Flag_C;
`endif

  logic [7:0] bank [16];
  int         ref_mem [16];
  int         total = 0;
  int         bad = 0;

  always #5 Clock = ~Clock;

  assign Out_A = bank[Addr_A];
  assign Out_B = bank[Addr_B];
  always @(posedge Clock) if (WR) bank[Addr_WR] <= DIN;

  regfile_sequencer #(.DATA_W(8), .ADDR_W(4), .NREG(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
    .Cmd_Rd(Cmd_Rd), .Cmd_Ra(Cmd_Ra), .Cmd_Rb(Cmd_Rb), .Cmd_Imm(Cmd_Imm),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .Out_A(Out_A), .Out_B(Out_B),
    .Addr_WR(Addr_WR), .WR(WR), .DIN(DIN), .Done(Done), .Result(Result)
`ifdef FLAGS_EN
    , .Flag_Z(Flag_Z), .Flag_C(Flag_C)
`endif
  );

  function automatic int model_res(input int op, input int a, input int b, input int imm);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return imm;
      6: return a;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_c(input int op, input int a, input int b);
    if (op == 0) return (a + b) > 255;
    if (op == 1) return a < b;
    return 1'b0;
  endfunction

  task automatic do_cmd(input int op, input int rd, input int ra, input int rb, input int imm);
    int exp_v;
    bit exp_c;
    exp_v = model_res(op, ref_mem[ra], ref_mem[rb], imm);
    exp_c = model_c(op, ref_mem[ra], ref_mem[rb]);
    @(negedge Clock);
    Cmd_Valid = 1'b1; Cmd_Op = 3'(op); Cmd_Rd = 4'(rd); Cmd_Ra = 4'(ra); Cmd_Rb = 4'(rb); Cmd_Imm = 8'(imm);
    total++;
    if (Cmd_Ready !== 1'b1) begin
      bad++; $display("FAIL ready_idle op=%0d got=%b want=1", op, Cmd_Ready);
    end
    @(negedge Clock);
    Cmd_Valid = 1'b0; Cmd_Op = 3'($urandom); Cmd_Imm = 8'($urandom);
    if (op != 5) begin
      total++;
      if ({WR, Cmd_Ready, Addr_A, Addr_B} !== {1'b0, 1'b0, 4'(ra), 4'(rb)}) begin
        bad++; $display("FAIL read_phase op=%0d got wr=%b rdy=%b a=%0d b=%0d want wr=0 rdy=0 a=%0d b=%0d",
                        op, WR, Cmd_Ready, Addr_A, Addr_B, ra, rb);
      end
      @(negedge Clock);
    end
    total++;
    if ({WR, Done, Cmd_Ready, Addr_WR, DIN} !== {1'b1, 1'b1, 1'b0, 4'(rd), 8'(exp_v)}) begin
      bad++; $display("FAIL write_phase op=%0d got wr=%b done=%b rdy=%b awr=%0d din=%h want 1 1 0 awr=%0d din=%h",
                      op, WR, Done, Cmd_Ready, Addr_WR, DIN, rd, exp_v[7:0]);
    end
    ref_mem[rd] = exp_v;
    @(negedge Clock);
    total++;
    if ({Result, Cmd_Ready, WR, Done} !== {8'(exp_v), 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL after_write op=%0d got res=%h rdy=%b wr=%b done=%b want res=%h rdy=1 wr=0 done=0",
                      op, Result, Cmd_Ready, WR, Done, exp_v[7:0]);
    end
`ifdef FLAGS_EN
    total++;
    if ({Flag_Z, Flag_C} !== {(exp_v == 0), exp_c}) begin
      bad++; $display("FAIL flags op=%0d got z=%b c=%b want z=%b c=%b", op, Flag_Z, Flag_C, (exp_v == 0), exp_c);
    end
`else
    if (exp_c && 0) $display("unused carry");
`endif
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bank[i] !== 8'(ref_mem[i])) begin
        bad++; $display("FAIL bank_%s r%0d got=%h want=%h", tag, i, bank[i], ref_mem[i][7:0]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge Clock);
    total++;
    if ({WR, Done, Addr_A, Addr_B, Addr_WR, DIN, Result} !== 30'd0) begin
      bad++; $display("FAIL reset_outputs got wr=%b done=%b a=%0d b=%0d awr=%0d din=%h res=%h want all 0",
                      WR, Done, Addr_A, Addr_B, Addr_WR, DIN, Result);
    end
`ifdef FLAGS_EN
    total++;
    if ({Flag_Z, Flag_C} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b%b want=00", Flag_Z, Flag_C);
    end
`endif
    Reset_n = 1'b1;
    @(negedge Clock);
    total++;
    if ({Cmd_Ready, WR, Done} !== 3'b100) begin
      bad++; $display("FAIL reset_release got rdy=%b wr=%b done=%b want 1 0 0", Cmd_Ready, WR, Done);
    end
  endtask

  task automatic test_ldi;
    for (int r = 0; r < 16; r++) do_cmd(5, r, 0, 0, int'($urandom_range(1, 255)));
    check_bank("ldi");
  endtask

  task automatic test_spec_examples;
    do_cmd(5, 3, 0, 0, 'h5A);
    do_cmd(0, 1, 3, 3, 0);
    total++;
    if (Result !== 8'hB4) begin
      bad++; $display("FAIL add_example got=%h want=b4", Result);
    end
    do_cmd(5, 0, 0, 0, 'h00);
    do_cmd(5, 2, 0, 0, 'h01);
    do_cmd(1, 4, 0, 2, 0);
    total++;
    if (Result !== 8'hFF) begin
      bad++; $display("FAIL sub_example got=%h want=ff", Result);
    end
  endtask

  task automatic test_alu_random;
    for (int n = 0; n < 60; n++)
      do_cmd(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    check_bank("alu");
  endtask

  task automatic test_back_to_back;
    int rds [3] = '{5, 6, 5};
    int ras [3] = '{1, 5, 6};
    int rbs [3] = '{2, 3, 5};
    int acc [$];
    int dn [$];
    int ci = 0;
    int nd = 0;
    bit pending = 0;
    int exp_v;
    @(negedge Clock);
    Cmd_Valid = 1'b1; Cmd_Op = 3'd4; Cmd_Rd = 4'(rds[0]); Cmd_Ra = 4'(ras[0]); Cmd_Rb = 4'(rbs[0]);
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge Clock);
      if (pending) begin
        pending = 0;
        ci++;
        if (ci < 3) begin
          Cmd_Rd = 4'(rds[ci]); Cmd_Ra = 4'(ras[ci]); Cmd_Rb = 4'(rbs[ci]);
        end else begin
          Cmd_Valid = 1'b0;
        end
      end
      if (Done === 1'b1) begin
        dn.push_back(cyc);
        if (nd < 3) begin
          exp_v = ref_mem[ras[nd]] ^ ref_mem[rbs[nd]];
          total++;
          if ({Addr_WR, DIN} !== {4'(rds[nd]), 8'(exp_v)}) begin
            bad++; $display("FAIL b2b_write%0d got awr=%0d din=%h want awr=%0d din=%h",
                            nd, Addr_WR, DIN, rds[nd], exp_v[7:0]);
          end
          ref_mem[rds[nd]] = exp_v;
        end
        nd++;
      end
      if (Cmd_Valid && Cmd_Ready === 1'b1) begin
        acc.push_back(cyc);
        pending = 1;
      end
    end
    Cmd_Valid = 1'b0;
    total++;
    if (acc.size() != 3 || dn.size() != 3) begin
      bad++; $display("FAIL b2b_counts got accepts=%0d dones=%0d want 3 3", acc.size(), dn.size());
    end else begin
      total++;
      if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
        bad++; $display("FAIL b2b_spacing got gaps=%0d,%0d want 3,3", acc[1] - acc[0], acc[2] - acc[1]);
      end
      total++;
      if (dn[1] - dn[0] < 2 || dn[2] - dn[1] < 2) begin
        bad++; $display("FAIL b2b_done_adjacent got gaps=%0d,%0d want >=2", dn[1] - dn[0], dn[2] - dn[1]);
      end
    end
    check_bank("b2b");
  endtask

  task automatic test_clear;
    @(negedge Clock);
    Cmd_Valid = 1'b1; Cmd_Op = 3'd7;
    @(negedge Clock);
    Cmd_Valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge Clock);
      total++;
      if ({WR, Done, Cmd_Ready, Addr_WR, DIN} !== {1'b1, (i == 15), 1'b0, 4'(i), 8'h00}) begin
        bad++; $display("FAIL clr_cycle%0d got wr=%b done=%b rdy=%b awr=%0d din=%h want 1 %0d 0 awr=%0d din=00",
                        i, WR, Done, Cmd_Ready, Addr_WR, DIN, (i == 15), i);
      end
    end
    @(negedge Clock);
    total++;
    if ({WR, Done, Cmd_Ready, Result} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      bad++; $display("FAIL clr_exit got wr=%b done=%b rdy=%b res=%h want 0 0 1 00", WR, Done, Cmd_Ready, Result);
    end
`ifdef FLAGS_EN
    total++;
    if ({Flag_Z, Flag_C} !== 2'b10) begin
      bad++; $display("FAIL clr_flags got=%b%b want=10", Flag_Z, Flag_C);
    end
`endif
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    check_bank("clr");
  endtask

  task automatic test_reset_mid_clear;
    bit found = 0;
    for (int r = 0; r < 16; r++) do_cmd(5, r, 0, 0, int'($urandom_range(1, 255)));
    @(negedge Clock);
    Cmd_Valid = 1'b1; Cmd_Op = 3'd7;
    for (int k = 0; k < 24 && !found; k++) begin
      @(negedge Clock);
      Cmd_Valid = 1'b0;
      if (WR === 1'b1 && Addr_WR === 4'd7) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rst_clr_reach got no WR at count 7 want one within 24 cycles");
    end
    Reset_n = 1'b0;
    #1;
    total++;
    if ({WR, Done} !== 2'b00) begin
      bad++; $display("FAIL rst_clr_drop got wr=%b done=%b want 0 0", WR, Done);
    end
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    total++;
    if ({Cmd_Ready, WR, Done, Result} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL rst_clr_release got rdy=%b wr=%b done=%b res=%h want 1 0 0 00", Cmd_Ready, WR, Done, Result);
    end
    for (int i = 0; i < 7; i++) ref_mem[i] = 0;
    check_bank("rstclr");
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_spec_examples();
    test_alu_random();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_alu_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
